// File: rtl/hilo_muldiv_ctrl_if.sv
// Operation handshake between the execute stage and the HI/LO mul/div unit.
// The execute stage is the master; hilo_muldiv_ctrl is the slave.
interface hilo_muldiv_ctrl_if;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        stall;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        div_zero;

  modport master (
    output flush, op_valid, op_code, rs_val, rt_val,
    input  op_ready, stall, busy, rd_valid, rd_data, div_zero
  );

  modport slave (
    input  flush, op_valid, op_code, rs_val, rt_val,
    output op_ready, stall, busy, rd_valid, rd_data, div_zero
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer and owner of the HI/LO registers.
// - MULT/MULTU: fixed MUL_LAT-cycle multiply (MUL_LAT legal range 1..8).
// - DIV/DIVU: 32-cycle restoring radix-2 divider followed by a FIX cycle
//   that applies signs and writes HI/LO.
// - MTHI/MTLO/MFHI/MFLO are serviced in IDLE.
// Optional feature macro HILO_BYPASS_EN: MFHI/MFLO are also accepted in the
// completion cycle and read the value being written.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // opa: multiplicand, or dividend magnitude that shifts into the quotient
  logic [31:0] opa_q, opa_d;
  // opb: multiplier, or divisor magnitude
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;    // signed multiply
  logic        qneg_q, qneg_d;  // negate quotient in FIX
  logic        rneg_q, rneg_d;  // negate remainder in FIX
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mf, accept, complete, wr_en;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] div_trial;
  logic        qbit;
  logic [31:0] rs_abs, rt_abs;
  logic [31:0] new_hi, new_lo;

  // Datapath: product of latched operands, divider trial subtract, FIX result
  always_comb begin
    mul_a     = {{32{sgn_q & opa_q[31]}}, opa_q};
    mul_b     = {{32{sgn_q & opb_q[31]}}, opb_q};
    prod      = mul_a * mul_b;
    // Remainder < divisor, so the shifted partial remainder minus the divisor
    // fits in 33 bits and bit 32 is the borrow.
    div_trial = {rem_q, opa_q[31]} - {1'b0, opb_q};
    qbit      = ~div_trial[32];
    rs_abs    = (bus.op_code == OP_DIV && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
    rt_abs    = (bus.op_code == OP_DIV && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
    if (state_q == S_FIX) begin
      new_lo = qneg_q ? -opa_q : opa_q;
      new_hi = rneg_q ? -rem_q : rem_q;
    end else begin
      new_lo = prod[31:0];
      new_hi = prod[63:32];
    end
  end

  // Handshake and result outputs
  always_comb begin
    is_mf    = (bus.op_code == OP_MFHI) || (bus.op_code == OP_MFLO);
    complete = ((state_q == S_MUL) && (cnt_q == 5'd0)) || (state_q == S_FIX);
    wr_en    = complete & ~bus.flush;
`ifdef HILO_BYPASS_EN
    bus.op_ready = (state_q == S_IDLE) || (complete && is_mf);
`else
    bus.op_ready = (state_q == S_IDLE);
`endif
    accept       = bus.op_valid & bus.op_ready & ~bus.flush;
    bus.stall    = bus.op_valid & ~bus.op_ready & ~bus.flush;
    bus.busy     = (state_q != S_IDLE);
    bus.rd_valid = accept & is_mf;
    bus.div_zero = accept && (bus.op_code == OP_DIV || bus.op_code == OP_DIVU)
                   && (bus.rt_val == 32'd0);
`ifdef HILO_BYPASS_EN
    if (complete)
      bus.rd_data = (bus.op_code == OP_MFHI) ? new_hi : new_lo;
    else
      bus.rd_data = (bus.op_code == OP_MFHI) ? hi_q : lo_q;
`else
    bus.rd_data = (bus.op_code == OP_MFHI) ? hi_q : lo_q;
`endif
  end

  // Next-state: sequencing FSM, divider iteration, HI/LO writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.op_code)
            OP_MULT, OP_MULTU: begin
              opa_d   = bus.rs_val;
              opb_d   = bus.rt_val;
              sgn_d   = (bus.op_code == OP_MULT);
              cnt_d   = 5'(MUL_LAT - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.rt_val == 32'd0) begin
                // FIX then writes LO=all ones, HI=dividend unchanged
                opa_d  = 32'hFFFF_FFFF;
                rem_d  = bus.rs_val;
                qneg_d = 1'b0;
                rneg_d = 1'b0;
                state_d = S_FIX;
              end else begin
                opa_d  = rs_abs;
                opb_d  = rt_abs;
                rem_d  = 32'd0;
                qneg_d = (bus.op_code == OP_DIV) & (bus.rs_val[31] ^ bus.rt_val[31]);
                rneg_d = (bus.op_code == OP_DIV) & bus.rs_val[31];
                cnt_d  = 5'd31;
                state_d = S_DIV;
              end
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_DIV: begin
        rem_d = qbit ? div_trial[31:0] : {rem_q[30:0], opa_q[31]};
        opa_d = {opa_q[30:0], qbit};
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_FIX: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      hi_d = new_hi;
      lo_d = new_lo;
    end

    if (bus.flush) state_d = S_IDLE;
  end

  // State register; synchronous active-low reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
